// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/result bundle between an issuing stage and the iterative mul/div unit.
interface ex_muldiv_if #(
    parameter int W = 32
) ();
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: MIPS-style HI/LO unit with radix-2 shift-add multiply and restoring divide.
module ex_muldiv #(
    parameter int W    = 32,
    parameter int CNTW = $clog2(W) + 1
) (
    input logic       CLK,
    input logic       RST,
    ex_muldiv_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [1:0]      state;
    logic [CNTW-1:0] cnt;
    logic [2*W-1:0]  p;
    logic [W-1:0]    m;
    logic            sa, sb, bz, dv;
    logic [W-1:0]    hi, lo;
    logic            done, dz;

    logic            accept, arith, sgn, asn, bsn;
    logic [W-1:0]    amag, bmag;
    logic [W:0]      msum, dt, dd;
    logic            dge, last;
    logic [2*W-1:0]  pfix;
    logic [W-1:0]    qfix, rfix;

    always_comb begin
        accept = bus.start & (state == IDLE);
        arith  = ~bus.op[2];
        sgn    = arith & ~bus.op[0];
        asn    = sgn & bus.a[W-1];
        bsn    = sgn & bus.b[W-1];
        amag   = asn ? -bus.a : bus.a;
        bmag   = bsn ? -bus.b : bus.b;
        msum   = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : {(W+1){1'b0}});
        dt     = {p[2*W-1:W], p[W-1]};
        dd     = dt - {1'b0, m};
        dge    = dt >= {1'b0, m};
        last   = cnt == CNTW'(W - 1);
        pfix   = (sa ^ sb) ? -p : p;
        qfix   = (sa ^ sb) ? -p[W-1:0] : p[W-1:0];
        rfix   = sa ? -p[2*W-1:W] : p[2*W-1:W];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            p     <= '0;
            m     <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            bz    <= 1'b0;
            dv    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            dz   <= 1'b0;
            if (accept) begin
                if (bus.op == OP_MTHI) hi <= bus.a;
                if (bus.op == OP_MTLO) lo <= bus.a;
                if (arith) begin
                    // Multiplier/dividend sits in the low half of p; the other operand in m.
                    p     <= {{W{1'b0}}, bus.op[1] ? amag : bmag};
                    m     <= bus.op[1] ? bmag : amag;
                    sa    <= asn;
                    sb    <= bsn;
                    bz    <= bus.b == '0;
                    dv    <= bus.op[1];
                    cnt   <= '0;
                    state <= bus.op[1] ? DIV : MUL;
                end
            end else if (state == MUL) begin
                p     <= {msum, p[W-1:1]};
                cnt   <= cnt + 1'b1;
                state <= last ? FIX : MUL;
            end else if (state == DIV) begin
                p     <= {dge ? dd[W-1:0] : dt[W-1:0], p[W-2:0], dge};
                cnt   <= cnt + 1'b1;
                state <= last ? FIX : DIV;
            end else if (state == FIX) begin
                state <= IDLE;
                done  <= 1'b1;
                dz    <= dv & bz;
                if (!(dv & bz)) begin
                    hi <= dv ? rfix : pfix[2*W-1:W];
                    lo <= dv ? qfix : pfix[W-1:0];
                end
            end
        end
    end

    assign bus.busy = state != IDLE;
    assign bus.done = done;
    assign bus.dz   = dz;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of ex_muldiv with W=32 against hand-computed results.
module tb_ex_muldiv;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, RSVD = 3'd6;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    ex_muldiv_if #(.W(32)) bus ();
    ex_muldiv #(.W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.start = 1'b1;
        bus.op = MTHI;
        bus.a = 32'h9;
        bus.b = 32'h0;
        step();
        step();
        bus.start = 1'b0;
        RST = 1'b0;
        total_cnt += 5;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
        if (bus.dz !== 1'b0) $display("FAIL reset_dz got %b want 0", bus.dz); else pass_cnt++;
        if (bus.hi !== 32'h0) $display("FAIL reset_hi got %h want 0", bus.hi); else pass_cnt++;
        if (bus.lo !== 32'h0) $display("FAIL reset_lo got %h want 0", bus.lo); else pass_cnt++;
    endtask

    task automatic test_multu();
        int n;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL multu_busy got %b want 1", bus.busy); else pass_cnt++;
        wait_done(n);
        total_cnt += 6;
        if (n !== 33) $display("FAIL multu_latency got %0d want 33", n); else pass_cnt++;
        if (bus.hi !== 32'hFFFFFFFE) $display("FAIL multu_hi got %h want fffffffe", bus.hi); else pass_cnt++;
        if (bus.lo !== 32'h00000001) $display("FAIL multu_lo got %h want 00000001", bus.lo); else pass_cnt++;
        if (bus.dz !== 1'b0) $display("FAIL multu_dz got %b want 0", bus.dz); else pass_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL multu_busy_done got %b want 0", bus.busy); else pass_cnt++;
        step();
        if (bus.done !== 1'b0) $display("FAIL multu_done_pulse got %b want 0", bus.done); else pass_cnt++;
    endtask

    task automatic test_mult();
        int n;
        issue(MULT, 32'hFFFFFFFD, 32'd7);
        repeat (10) step();
        total_cnt += 5;
        if (bus.hi !== 32'hFFFFFFFE) $display("FAIL mult_hold_hi got %h want fffffffe", bus.hi); else pass_cnt++;
        if (bus.lo !== 32'h00000001) $display("FAIL mult_hold_lo got %h want 00000001", bus.lo); else pass_cnt++;
        wait_done(n);
        if (n + 10 !== 33) $display("FAIL mult_latency got %0d want 33", n + 10); else pass_cnt++;
        if (bus.hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h want ffffffff", bus.hi); else pass_cnt++;
        if (bus.lo !== 32'hFFFFFFEB) $display("FAIL mult_lo got %h want ffffffeb", bus.lo); else pass_cnt++;
    endtask

    task automatic test_div();
        int n;
        logic [2:0]  ops [4] = '{DIV, DIV, DIV, DIVU};
        logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7};
        logic [31:0] qs  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'd14};
        logic [31:0] rs  [4] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd2};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(n);
            total_cnt += 4;
            if (n !== 33) $display("FAIL div%0d_latency got %0d want 33", i, n); else pass_cnt++;
            if (bus.lo !== qs[i]) $display("FAIL div%0d_lo got %h want %h", i, bus.lo, qs[i]); else pass_cnt++;
            if (bus.hi !== rs[i]) $display("FAIL div%0d_hi got %h want %h", i, bus.hi, rs[i]); else pass_cnt++;
            if (bus.dz !== 1'b0) $display("FAIL div%0d_dz got %b want 0", i, bus.dz); else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        int n;
        issue(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n);
        total_cnt += 3;
        if (bus.lo !== 32'h80000000) $display("FAIL ovf_lo got %h want 80000000", bus.lo); else pass_cnt++;
        if (bus.hi !== 32'h0) $display("FAIL ovf_hi got %h want 0", bus.hi); else pass_cnt++;
        if (bus.dz !== 1'b0) $display("FAIL ovf_dz got %b want 0", bus.dz); else pass_cnt++;
    endtask

    task automatic test_divzero();
        int n;
        issue(MTHI, 32'd5, 32'd0);
        issue(MTLO, 32'd9, 32'd0);
        issue(DIVU, 32'd100, 32'd0);
        wait_done(n);
        total_cnt += 6;
        if (n !== 33) $display("FAIL dz_latency got %0d want 33", n); else pass_cnt++;
        if (bus.dz !== 1'b1) $display("FAIL dz_flag got %b want 1", bus.dz); else pass_cnt++;
        if (bus.hi !== 32'd5) $display("FAIL dz_hi got %h want 5", bus.hi); else pass_cnt++;
        if (bus.lo !== 32'd9) $display("FAIL dz_lo got %h want 9", bus.lo); else pass_cnt++;
        step();
        if (bus.dz !== 1'b0) $display("FAIL dz_pulse got %b want 0", bus.dz); else pass_cnt++;
        if (bus.done !== 1'b0) $display("FAIL dz_done_pulse got %b want 0", bus.done); else pass_cnt++;
    endtask

    task automatic test_mtlo_divu();
        int n;
        issue(MTLO, 32'h1234, 32'd0);
        total_cnt += 6;
        if (bus.lo !== 32'h1234) $display("FAIL mtlo_lo got %h want 1234", bus.lo); else pass_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL mtlo_busy got %b want 0", bus.busy); else pass_cnt++;
        issue(DIVU, 32'd10, 32'd3);
        wait_done(n);
        if (n !== 33) $display("FAIL mtlo_divu_latency got %0d want 33", n); else pass_cnt++;
        if (bus.lo !== 32'd3) $display("FAIL mtlo_divu_lo got %h want 3", bus.lo); else pass_cnt++;
        if (bus.hi !== 32'd1) $display("FAIL mtlo_divu_hi got %h want 1", bus.hi); else pass_cnt++;
        step();
        if (bus.done !== 1'b0) $display("FAIL mtlo_divu_pulse got %b want 0", bus.done); else pass_cnt++;
    endtask

    task automatic test_reserved();
        int d = 0;
        issue(MTHI, 32'hAA, 32'd0);
        issue(RSVD, 32'h77, 32'h77);
        total_cnt += 4;
        if (bus.busy !== 1'b0) $display("FAIL rsvd_busy got %b want 0", bus.busy); else pass_cnt++;
        if (bus.hi !== 32'hAA) $display("FAIL rsvd_hi got %h want aa", bus.hi); else pass_cnt++;
        if (bus.lo !== 32'd3) $display("FAIL rsvd_lo got %h want 3", bus.lo); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) d++;
            step();
        end
        if (d !== 0) $display("FAIL rsvd_done got %0d pulses want 0", d); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        int d = 0;
        issue(MULTU, 32'd6, 32'd7);
        wait_done(n);
        total_cnt += 7;
        if (bus.lo !== 32'd42) $display("FAIL b2b_mul_lo got %h want 2a", bus.lo); else pass_cnt++;
        if (bus.hi !== 32'd0) $display("FAIL b2b_mul_hi got %h want 0", bus.hi); else pass_cnt++;
        issue(DIVU, 32'd45, 32'd6);
        if (bus.busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", bus.busy); else pass_cnt++;
        repeat (3) step();
        issue(MULTU, 32'd2, 32'd2);
        wait_done(n);
        if (n + 4 !== 33) $display("FAIL b2b_latency got %0d want 33", n + 4); else pass_cnt++;
        if (bus.lo !== 32'd7) $display("FAIL b2b_div_lo got %h want 7", bus.lo); else pass_cnt++;
        if (bus.hi !== 32'd3) $display("FAIL b2b_div_hi got %h want 3", bus.hi); else pass_cnt++;
        step();
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) d++;
            step();
        end
        if (d !== 0) $display("FAIL b2b_ignored_start got %0d pulses want 0", d); else pass_cnt++;
    endtask

    task automatic test_abort();
        int d = 0;
        issue(MTHI, 32'h55, 32'd0);
        issue(MTLO, 32'h66, 32'd0);
        issue(MULT, 32'd3, 32'd5);
        repeat (4) step();
        issue(MTHI, 32'd1, 32'd0);
        total_cnt += 5;
        if (bus.hi !== 32'h55) $display("FAIL abort_mthi_ignored got %h want 55", bus.hi); else pass_cnt++;
        repeat (4) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else pass_cnt++;
        if (bus.hi !== 32'h0) $display("FAIL abort_hi got %h want 0", bus.hi); else pass_cnt++;
        if (bus.lo !== 32'h0) $display("FAIL abort_lo got %h want 0", bus.lo); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) d++;
            step();
        end
        if (d !== 0) $display("FAIL abort_done got %0d pulses want 0", d); else pass_cnt++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_overflow();
        test_divzero();
        test_mtlo_divu();
        test_reserved();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
